// File: rtl/free_list.sv
// free_list: R10K physical-register free list (circular FIFO of free tags).
// Optional macro FREE_LIST_BYPASS_EN: same-cycle handoff of a freed tag when empty.
package free_list_pkg;
    localparam int NUM_PHYS_REGS = 64;
    localparam int PW = $clog2(NUM_PHYS_REGS);

    typedef struct packed {
        logic [PW-1:0] phys_reg;
        logic          valid;
        logic          ready;
    } TAG;

    typedef struct packed {
        logic retire_en;
        TAG   retire_t;
        TAG   retire_t_old;
    } IR_MT_PACKET;
endpackage

module free_list
    import free_list_pkg::*;
#(
    parameter int NUM_PHYS = NUM_PHYS_REGS,
    parameter int NUM_ARCH = 32,
    parameter int DEPTH    = NUM_PHYS - NUM_ARCH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     interrupt,
    input  logic                     alloc_req,
    output logic                     alloc_valid,
    output TAG                       alloc_tag,
    input  IR_MT_PACKET              ir_fl_packet,
    output logic [$clog2(DEPTH):0]   free_count,
    output logic                     empty,
    output logic                     overflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PW-1:0] fifo_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW-1:0] rhead_q, rhead_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] spec_q, spec_d;
    logic          ovf_q, ovf_d;

    logic          free_fire, alloc_fire, bypass, byp_take;
    logic          pop, push, commit, full;
    logic [PW-1:0] old_tag;
    logic          unused_ok;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign old_tag   = ir_fl_packet.retire_t_old.phys_reg;
    assign free_fire = ir_fl_packet.retire_en && (old_tag != '0) && !interrupt;
    assign full      = (count_q == CW'(DEPTH));

`ifdef FREE_LIST_BYPASS_EN
    assign bypass = free_fire && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign alloc_valid = (count_q != '0) || bypass;
    assign alloc_fire  = alloc_req && alloc_valid && !interrupt;
    assign byp_take    = bypass && alloc_fire;
    assign pop         = alloc_fire && !byp_take;
    assign push        = free_fire && !byp_take && !full;
    assign commit      = free_fire && (spec_q != '0);

    always_comb begin
        alloc_tag          = '0;
        alloc_tag.phys_reg = bypass ? old_tag : fifo_q[head_q];
        alloc_tag.valid    = 1'b1;
        alloc_tag.ready    = 1'b0;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        rhead_d = rhead_q;
        count_d = count_q;
        spec_d  = spec_q;
        ovf_d   = ovf_q;
        if (interrupt) begin
            // Roll back to the oldest unretired allocation.
            head_d  = rhead_q;
            count_d = count_q + spec_q;
            spec_d  = '0;
        end else begin
            if (pop)    head_d  = inc(head_q);
            if (push)   tail_d  = inc(tail_q);
            if (commit) rhead_d = inc(rhead_q);
            count_d = count_q + CW'(push) - CW'(pop);
            spec_d  = spec_q + CW'(alloc_fire) - CW'(commit);
            if (free_fire && !byp_take && full) ovf_d = 1'b1;
            if (free_fire && (spec_q == '0))    ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            rhead_q <= '0;
            count_q <= CW'(DEPTH);
            spec_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            rhead_q <= rhead_d;
            count_q <= count_d;
            spec_q  <= spec_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= PW'(NUM_ARCH + i);
            end
        end else if (push) begin
            fifo_q[tail_q] <= old_tag;
        end
    end

    assign free_count   = count_q;
    assign empty        = (count_q == '0);
    assign overflow_err = ovf_q;

    assign unused_ok = ^{ir_fl_packet.retire_t,
                         ir_fl_packet.retire_t_old.valid,
                         ir_fl_packet.retire_t_old.ready};
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed scoreboard bench for the rename free list.
// Expected allocation tags are queued when stimulus is planned, popped on grant.
module tb_free_list;
    import free_list_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        interrupt;
    logic        alloc_req;
    logic        alloc_valid;
    TAG          alloc_tag;
    IR_MT_PACKET pkt;
    logic [5:0]  free_count;
    logic        empty;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    free_list dut (
        .clock       (clock),
        .reset       (reset),
        .interrupt   (interrupt),
        .alloc_req   (alloc_req),
        .alloc_valid (alloc_valid),
        .alloc_tag   (alloc_tag),
        .ir_fl_packet(pkt),
        .free_count  (free_count),
        .empty       (empty),
        .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        interrupt = 1'b0;
        alloc_req = 1'b0;
        pkt       = '0;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic alloc_n(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            int e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            alloc_req = 1'b1;
            check({tag, "_valid"}, alloc_valid, 1);
            check({tag, "_tag"}, alloc_tag.phys_reg, e);
            step();
        end
        alloc_req = 1'b0;
    endtask

    task automatic set_retire(input int phys);
        pkt                       = '0;
        pkt.retire_en             = 1'b1;
        pkt.retire_t_old.phys_reg = 6'(phys);
        pkt.retire_t_old.valid    = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_valid", alloc_valid, 1);
        check("rst_tag", alloc_tag.phys_reg, 32);
        check("rst_count", free_count, 32);
        check("rst_empty", empty, 0);
        check("rst_ovf", overflow_err, 0);

        // Drain the whole list; tags come out 32..63 in order.
        for (int t = 32; t < 64; t++) exp_q.push_back(t);
        alloc_n(32, "drain");
        check("drain_count", free_count, 0);
        check("drain_empty", empty, 1);
        check("drain_valid", alloc_valid, 0);
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        check("stall_count", free_count, 0);

        // Free phys 5 while empty.
        set_retire(5);
`ifdef FREE_LIST_BYPASS_EN
        alloc_req = 1'b1;
        check("byp_valid", alloc_valid, 1);
        check("byp_tag", alloc_tag.phys_reg, 5);
        step();
        pkt = '0;
        alloc_req = 1'b0;
        check("byp_count", free_count, 0);
`else
        check("nobyp_valid", alloc_valid, 0);
        step();
        pkt = '0;
        check("ref_valid", alloc_valid, 1);
        check("ref_tag", alloc_tag.phys_reg, 5);
        check("ref_count", free_count, 1);
`endif

        // Alloc 32,33,34, retire (t_old 7), then interrupt.
        do_reset();
        for (int t = 32; t < 35; t++) exp_q.push_back(t);
        alloc_n(3, "sp3");
        set_retire(7);
        step();
        pkt = '0;
        check("sp3_count_ret", free_count, 30);
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        check("sp3_count_int", free_count, 32);
        check("sp3_tag_int", alloc_tag.phys_reg, 33);
        for (int t = 33; t < 64; t++) exp_q.push_back(t);
        exp_q.push_back(7);
        alloc_n(32, "sp3_wrap");
        check("sp3_wrap_empty", empty, 1);

        // Interrupt coincident with retire of phys 9.
        do_reset();
        exp_q.push_back(32);
        exp_q.push_back(33);
        alloc_n(2, "irq");
        set_retire(9);
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        pkt = '0;
        check("irq_count", free_count, 32);
        check("irq_ovf", overflow_err, 0);
        for (int t = 32; t < 64; t++) exp_q.push_back(t);
        alloc_n(32, "irq_all");
        check("irq_empty", empty, 1);

        // Retire of r0 mapping is ignored entirely.
        do_reset();
        exp_q.push_back(32);
        alloc_n(1, "r0");
        set_retire(0);
        step();
        pkt = '0;
        check("r0_count", free_count, 31);
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        check("r0_count_int", free_count, 32);
        check("r0_tag_int", alloc_tag.phys_reg, 32);

        // Free while full sets a sticky error.
        do_reset();
        set_retire(3);
        step();
        pkt = '0;
        check("ovf_set", overflow_err, 1);
        check("ovf_count", free_count, 32);
        check("ovf_tag", alloc_tag.phys_reg, 32);
        step();
        step();
        check("ovf_sticky", overflow_err, 1);
        do_reset();
        check("ovf_clear", overflow_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
